// File: rtl/decode_stage_if.sv
// Fetch-to-execute boundary of the decode stage: instruction handshake in,
// decoded-field handshake out.
interface decode_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           instruction;
  logic [2:0]            cond_bits;
  logic                  flags_valid;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            destination_reg;
  logic [2:0]            first_reg;
  logic [2:0]            second_reg;
  logic [DATA_WIDTH-1:0] out_offset;
  logic [2:0]            alu_op;
  logic                  ram_read;
  logic                  ram_write;
  logic                  branch_taken;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output in_valid, instruction, cond_bits, flags_valid, flush, out_ready,
    input  in_ready, out_valid, destination_reg, first_reg, second_reg,
           out_offset, alu_op, ram_read, ram_write, branch_taken, stall_cnt
  );

  modport slave (
    input  in_valid, instruction, cond_bits, flags_valid, flush, out_ready,
    output in_ready, out_valid, destination_reg, first_reg, second_reg,
           out_offset, alu_op, ram_read, ram_write, branch_taken, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decoder between fetch and execute: one-entry output
// register, optional flag-wait for conditional branches, flush, stall counter.
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_REG     = 6,
  parameter bit FLAG_WAIT  = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  decode_stage_if.slave  bus
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t state, state_next;

  logic [15:0]           instr;
  logic [2:0]            cond;
  logic                  cond_branch;
  logic                  cond_true;
  logic                  stall_wait;
  logic                  in_ready;
  logic                  accept;
  logic                  out_valid;

  logic [2:0]            d_dst, d_first, d_second, d_alu;
  logic [DATA_WIDTH-1:0] d_offset;
  logic                  d_rd, d_wr, d_taken;

  logic [2:0]            dst_q, first_q, second_q, alu_q;
  logic [DATA_WIDTH-1:0] offset_q;
  logic                  rd_q, wr_q, taken_q;
  logic [CNT_W-1:0]      stall_cnt_q;

  assign instr       = bus.instruction;
  assign cond        = instr[14:12];
  assign cond_branch = instr[15] && (cond inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110});
  assign stall_wait  = FLAG_WAIT && bus.in_valid && cond_branch && !bus.flags_valid;
  assign out_valid   = (state == ST_FULL);
  assign in_ready    = !bus.flush && !stall_wait && (!out_valid || bus.out_ready);
  assign accept      = bus.in_valid && in_ready;

  // cond_bits: [0]=less, [1]=greater, [2]=zero
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = bus.cond_bits[0];
      3'b010:  cond_true = bus.cond_bits[1];
      3'b100:  cond_true = bus.cond_bits[2];
      3'b101:  cond_true = bus.cond_bits[0] | bus.cond_bits[2];
      3'b110:  cond_true = bus.cond_bits[1] | bus.cond_bits[2];
      default: cond_true = 1'b0;
    endcase
  end

  // Field decode; classes are checked in priority order, anything else is a NOP.
  always_comb begin
    d_dst    = 3'd0;
    d_first  = 3'd0;
    d_second = 3'd0;
    d_offset = '0;
    d_alu    = 3'b100;
    d_rd     = 1'b0;
    d_wr     = 1'b0;
    d_taken  = 1'b0;
    if (instr[15]) begin
      d_dst   = 3'(PC_REG);
      d_first = 3'(PC_REG);
      d_taken = cond_true;
      if (cond_true)
        d_offset = {{(DATA_WIDTH-12){instr[11]}}, instr[11:0]};
      else
        d_offset = DATA_WIDTH'(1);
    end else if (instr[14]) begin
      d_dst    = instr[12:10];
      d_first  = instr[9:7];
      d_offset = {{(DATA_WIDTH-7){instr[6]}}, instr[6:0]};
      d_rd     = !instr[13];
      d_wr     = instr[13];
    end else if (instr[13:11] == 3'b000) begin
      d_dst    = instr[10:8];
      d_first  = instr[7:5];
      d_offset = {{(DATA_WIDTH-5){instr[4]}}, instr[4:0]};
      d_alu    = 3'b000;
    end else if (instr[13:11] == 3'b001) begin
      d_dst    = instr[8:6];
      d_first  = instr[5:3];
      d_second = instr[2:0];
      d_alu    = {1'b1, instr[10:9]};
    end else if (instr[13]) begin
      d_dst    = instr[10:8];
      d_first  = instr[7:5];
      d_offset = {{(DATA_WIDTH-5){instr[4]}}, instr[4:0]};
      d_alu    = {1'b1, instr[12:11]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_EMPTY;
    else
      state <= state_next;
  end

  // Flush wins over both handoff and accept.
  always_comb begin
    state_next = state;
    if (bus.flush)
      state_next = ST_EMPTY;
    else if (accept)
      state_next = ST_FULL;
    else if (out_valid && bus.out_ready)
      state_next = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_q    <= 3'd0;
      first_q  <= 3'd0;
      second_q <= 3'd0;
      offset_q <= '0;
      alu_q    <= 3'b100;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      taken_q  <= 1'b0;
    end else if (accept) begin
      dst_q    <= d_dst;
      first_q  <= d_first;
      second_q <= d_second;
      offset_q <= d_offset;
      alu_q    <= d_alu;
      rd_q     <= d_rd;
      wr_q     <= d_wr;
      taken_q  <= d_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_q <= '0;
    else if (stall_wait && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.destination_reg = dst_q;
  assign bus.first_reg       = first_q;
  assign bus.second_reg      = second_q;
  assign bus.out_offset      = offset_q;
  assign bus.alu_op          = alu_q;
  assign bus.ram_read        = rd_q;
  assign bus.ram_write       = wr_q;
  assign bus.branch_taken    = taken_q;
  assign bus.stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random traffic,
// with a second instance (CNT_W=2) sharing inputs to observe counter saturation.
module tb_decode_stage;

  typedef struct packed {
    logic [2:0]  dst;
    logic [2:0]  first;
    logic [2:0]  second;
    logic [15:0] offset;
    logic [2:0]  alu;
    logic        rd;
    logic        wr;
    logic        taken;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cnt_main = 0;
  int   cnt_sat = 0;
  exp_t sb_q[$];

  decode_stage_if #(.DATA_WIDTH(16), .CNT_W(8)) bus ();
  decode_stage_if #(.DATA_WIDTH(16), .CNT_W(2)) bus_sat ();

  decode_stage #(.DATA_WIDTH(16), .PC_REG(6), .FLAG_WAIT(1'b1), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  decode_stage #(.DATA_WIDTH(16), .PC_REG(6), .FLAG_WAIT(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus_sat)
  );

  assign bus_sat.in_valid    = bus.in_valid;
  assign bus_sat.instruction = bus.instruction;
  assign bus_sat.cond_bits   = bus.cond_bits;
  assign bus_sat.flags_valid = bus.flags_valid;
  assign bus_sat.flush       = bus.flush;
  assign bus_sat.out_ready   = bus.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sext(input int value, input int bits);
    int v;
    v = value;
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  // Reference decode from the instruction-class table.
  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [2:0] cb);
    exp_t e;
    bit   less, greater, zero, taken;
    int   cls;
    e = '0;
    e.alu = 3'd4;
    less = cb[0]; greater = cb[1]; zero = cb[2];
    cls = int'(ins[15:11]);
    if (ins[15]) begin
      case (int'(ins[14:12]))
        0: taken = 1;
        1: taken = less;
        2: taken = greater;
        4: taken = zero;
        5: taken = less || zero;
        6: taken = greater || zero;
        default: taken = 0;
      endcase
      e.dst = 3'd6; e.first = 3'd6; e.taken = taken;
      e.offset = taken ? sext(int'(ins[11:0]), 12) : 16'd1;
    end else if (cls >= 8 && cls < 16) begin
      e.dst = ins[12:10]; e.first = ins[9:7];
      e.offset = sext(int'(ins[6:0]), 7);
      e.rd = (ins[13] == 1'b0); e.wr = (ins[13] == 1'b1);
    end else if (cls == 0) begin
      e.dst = ins[10:8]; e.first = ins[7:5];
      e.offset = sext(int'(ins[4:0]), 5); e.alu = 3'd0;
    end else if (cls == 1) begin
      e.dst = ins[8:6]; e.first = ins[5:3]; e.second = ins[2:0];
      e.alu = 3'd4 + 3'(ins[10:9]);
    end else if (cls >= 4 && cls < 8) begin
      e.dst = ins[10:8]; e.first = ins[7:5];
      e.offset = sext(int'(ins[4:0]), 5); e.alu = 3'd4 + 3'(ins[12:11]);
    end
    return e;
  endfunction

  function automatic exp_t dut_fields();
    exp_t a;
    a = {bus.destination_reg, bus.first_reg, bus.second_reg, bus.out_offset,
         bus.alu_op, bus.ram_read, bus.ram_write, bus.branch_taken};
    return a;
  endfunction

  // Monitor: compares the presented entry against the scoreboard head and
  // retires it on a handoff.
  initial begin
    exp_t a;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("out_valid", bus.out_valid, (sb_q.size() != 0));
        if (bus.out_valid && sb_q.size() != 0) begin
          a = dut_fields();
          chk("fields", a, sb_q[0]);
          if (bus.out_ready && !bus.flush) void'(sb_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; called and returning at posedge + 1.
  task automatic apply_stimulus(input logic v, input logic [15:0] ins, input logic [2:0] cb,
                                input logic fv, input logic fl, input logic ordy);
    bit waiting, ready;
    bus.in_valid = v; bus.instruction = ins; bus.cond_bits = cb;
    bus.flags_valid = fv; bus.flush = fl; bus.out_ready = ordy;
    @(negedge clk);
    #1;
    waiting = v && ins[15] && (int'(ins[14:12]) inside {1, 2, 4, 5, 6}) && !fv;
    ready = !fl && !waiting && (sb_q.size() == 0 || ordy);
    chk("in_ready", bus.in_ready, ready);
    @(posedge clk);
    if (fl) sb_q.delete();
    if (v && ready) sb_q.push_back(ref_decode(ins, cb));
    if (waiting) begin
      if (cnt_main < 255) cnt_main++;
      if (cnt_sat < 3) cnt_sat++;
    end
    #1;
    chk("stall_cnt", bus.stall_cnt, cnt_main);
    chk("stall_cnt_w2", bus_sat.stall_cnt, cnt_sat);
  endtask

  task automatic check_output(input string name, input exp_t e);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk(name, dut_fields(), e);
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.instruction = 0; bus.cond_bits = 0;
    bus.flags_valid = 1; bus.flush = 0; bus.out_ready = 1;
    reset_n = 0;
    sb_q.delete();
    cnt_main = 0; cnt_sat = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  initial begin
    exp_t snap;
    logic [15:0] ins;
    do_reset();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_fields", dut_fields(), {3'd0, 3'd0, 3'd0, 16'd0, 3'b100, 1'b0, 1'b0, 1'b0});
    chk("rst_stall", bus.stall_cnt, 0);

    // ALU reg-reg, then load/store streamed back to back
    apply_stimulus(1, 16'h0A4C, 3'b000, 1, 0, 1);
    check_output("alu_rr", {3'd1, 3'd1, 3'd4, 16'h0000, 3'b101, 1'b0, 1'b0, 1'b0});
    apply_stimulus(1, 16'h4A7F, 3'b000, 1, 0, 1);
    check_output("load", {3'd2, 3'd4, 3'd0, 16'hFFFF, 3'b100, 1'b1, 1'b0, 1'b0});
    apply_stimulus(1, 16'h6A01, 3'b000, 1, 0, 1);
    check_output("store", {3'd2, 3'd4, 3'd0, 16'h0001, 3'b100, 1'b0, 1'b1, 1'b0});
    apply_stimulus(1, 16'h1000, 3'b000, 1, 0, 1);
    check_output("nop", {3'd0, 3'd0, 3'd0, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0});
    apply_stimulus(0, 16'h0000, 3'b000, 1, 0, 1);

    // Conditional branch waiting on flags
    do_reset();
    repeat (3) apply_stimulus(1, 16'h9FFE, 3'b001, 0, 0, 1);
    chk("stall_three", bus.stall_cnt, 3);
    apply_stimulus(1, 16'h9FFE, 3'b001, 1, 0, 1);
    check_output("br_taken", {3'd6, 3'd6, 3'd0, 16'hFFFE, 3'b100, 1'b0, 1'b0, 1'b1});
    apply_stimulus(1, 16'h9FFE, 3'b010, 1, 0, 1);
    check_output("br_not_taken", {3'd6, 3'd6, 3'd0, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0});

    // Back-pressure: entry held and stable, then one handoff and a new accept
    apply_stimulus(1, 16'h0A4C, 3'b000, 1, 0, 1);
    snap = dut_fields();
    repeat (5) begin
      apply_stimulus(1, 16'h4A7F, 3'b000, 1, 0, 0);
      chk("hold_stable", dut_fields(), snap);
    end
    apply_stimulus(1, 16'h4A7F, 3'b000, 1, 0, 1);
    check_output("after_hold", {3'd2, 3'd4, 3'd0, 16'hFFFF, 3'b100, 1'b1, 1'b0, 1'b0});

    // Flush with an entry held and a new instruction offered
    apply_stimulus(1, 16'h6A01, 3'b000, 1, 1, 1);
    chk("flush_valid", bus.out_valid, 1'b0);
    apply_stimulus(0, 16'h0000, 3'b000, 1, 0, 1);

    // Asynchronous reset in the middle of a cycle
    apply_stimulus(1, 16'h0A4C, 3'b000, 1, 0, 0);
    #2 reset_n = 0;
    #1;
    chk("async_valid", bus.out_valid, 1'b0);
    chk("async_alu", bus.alu_op, 3'b100);
    do_reset();

    // Counter saturation on the narrow instance
    repeat (5) apply_stimulus(1, 16'hC123, 3'b000, 0, 0, 1);
    chk("sat_w2", bus_sat.stall_cnt, 3);
    chk("sat_w8", bus.stall_cnt, 5);
    apply_stimulus(0, 16'h0000, 3'b000, 1, 0, 1);

    // Randomized traffic over all instruction classes
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: ins = {1'b1, 15'($urandom)};
        1: ins = {2'b01, 14'($urandom)};
        2: ins = {5'b00000, 11'($urandom)};
        3: ins = {5'b00001, 11'($urandom)};
        4: ins = {3'b001, 13'($urandom)};
        5: ins = {4'b0001, 12'($urandom)};
        default: ins = 16'($urandom);
      endcase
      apply_stimulus($urandom_range(0, 9) < 8, ins, 3'($urandom),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 3) != 0);
    end
    repeat (2) apply_stimulus(0, 16'h0000, 3'b000, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder. It sits between fetch and execute.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into register selects, offset, ALU op and RAM strobes, with one cycle of latency.
- Additions over the combinational decoder:
  - parametrised datapath width and PC register index;
  - optional stall of conditional branches until the condition flags are valid;
  - pipeline flush;
  - a saturating stall-cycle counter.

Parameters:
- DATA_WIDTH, 16: width of `out_offset`. Must be >= 16. All offsets are sign-extended to this width.
- PC_REG, 6: register index used as the PC for branches. Range 0..7.
- FLAG_WAIT, 1: 1 makes conditional branches wait for `flags_valid`. 0 decodes them with current flags.
- CNT_W, 8: width of `stall_cnt`.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts this cycle
- instruction  in  16  instruction word
- cond_bits  in  3  flags: [0]=less, [1]=greater, [2]=zero
- flags_valid  in  1  `cond_bits` reflects all retired instructions
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  decoded fields valid
- out_ready  in  1  execute accepts
- destination_reg  out  3  destination register select
- first_reg  out  3  first source register select
- second_reg  out  3  second source register select
- out_offset  out  DATA_WIDTH  offset / immediate
- alu_op  out  3  ALU operation
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- branch_taken  out  1  branch resolved taken
- stall_cnt  out  CNT_W  saturating count of flag-wait cycles

Behaviour:
- Reset (async, `reset_n`=0) values:
  - `out_valid`=0;
  - register selects=0, `out_offset`=0;
  - `alu_op`=3'b100;
  - `ram_read`/`ram_write`/`branch_taken`=0;
  - `stall_cnt`=0.
  - Reset mid-transfer discards the held entry.
- Unless otherwise stated below, a field is 0 for the instruction class. `sext(x)` means sign extension to DATA_WIDTH.
- Decode priority:
  1. Branch, `instr[15]`=1:
     - dst=first=PC_REG, second=0, `alu_op`=100, no RAM strobes.
     - `cond`=`instr[14:12]`:
       - 000 always;
       - 001 `cond_bits[0]`;
       - 010 `cond_bits[1]`;
       - 100 `cond_bits[2]`;
       - 101 [0]|[2];
       - 110 [1]|[2];
       - 011/111 never taken.
     - Taken: `offset`=sext(`instr[11:0]`), `branch_taken`=1. Not taken: `offset`=1, `branch_taken`=0.
  2. Load/store, `instr[15:14]`=01:
     - dst=[12:10], first=[9:7], second=0.
     - `offset`=sext([6:0]), `alu_op`=100.
     - `ram_read`=~[13], `ram_write`=[13].
  3. Shift, `instr[15:11]`=00000: dst=[10:8], first=[7:5], `offset`=sext([4:0]), `alu_op`=000.
  4. ALU register-register, `instr[15:11]`=00001: dst=[8:6], first=[5:3], second=[2:0], `offset`=0, `alu_op`={1,[10:9]}.
  5. ALU register-immediate, `instr[15:13]`=001: dst=[10:8], first=[7:5], `offset`=sext([4:0]), `alu_op`={1,[12:11]}.
  6. Otherwise NOP: all selects 0, `offset`=0, `alu_op`=100, no strobes.
- Conditional branch: a branch whose cond is in {001, 010, 100, 101, 110}.
- wait (combinational) = FLAG_WAIT & `in_valid` & conditional branch & ~`flags_valid`.
- `in_ready` = ~`flush` & ~wait & (~`out_valid` | `out_ready`). It is combinational from the inputs and `out_valid`.
- Accept = `in_valid` & `in_ready`.
  - On accept, all decoded fields register at the next edge and `out_valid`=1.
  - Latency 1 cycle. Throughput 1/cycle when `out_ready` is held high.
  - Branch condition is evaluated with the `cond_bits` sampled at the accept edge.
- If `out_valid` & `out_ready` & ~accept, `out_valid`→0. Field registers hold their last values.
- Output fields are stable while `out_valid`=1 & `out_ready`=0.
- `flush`=1 gives `out_valid`=0 at the next edge. The input is not accepted that cycle, and `flush` overrides a simultaneous `out_ready`/accept.
- `stall_cnt` increments on each cycle with wait=1 and saturates at all-ones. Cleared only by reset.
- FLAG_WAIT=0: wait is always 0 and `stall_cnt` stays 0.

Test Plan:
1. Reset, then accept 16'h0A4C (ALU register-register) with `out_ready`=1:
   - next cycle `out_valid`=1, dst=1, first=1, second=4, `alu_op`=101, `out_offset`=0;
   - back-to-back instructions stream 1/cycle.
2. 16'h4A7F (load): dst=2, first=4, `out_offset`=16'hFFFF (DATA_WIDTH=16), `ram_read`=1, `ram_write`=0. 16'h6A01 (store): `ram_write`=1, `ram_read`=0.
3. 16'h9FFE (branch-less, offset -2) with `flags_valid`=0:
   - `in_ready`=0 for 3 cycles, `stall_cnt`=3;
   - then `flags_valid`=1, `cond_bits`=001 → dst=first=6, `out_offset`=16'hFFFE, `branch_taken`=1.
   - Repeat with `cond_bits`=010 → `out_offset`=1, `branch_taken`=0.
4. Hold `out_ready`=0 with an entry held → `in_ready`=0 and outputs stable for 5 cycles. Release → one handoff, then the next instruction is accepted.
5. Assert `flush` with `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0, no accept that cycle. Assert `reset_n`=0 mid-stream → `out_valid`=0 and `alu_op`=100 immediately (asynchronous).
6. 16'h1000 (unused opcode) → NOP fields. With CNT_W=2, 5 wait cycles → `stall_cnt` saturates at 3.
